// File: rtl/rstatus_reader.sv
// Consumer end of the rstatus ($r30) path: X->M->W write pipe, commit, bex forwarding,
// cause decode and per-cause overflow counters (counters only with RSTATUS_COUNTERS_EN).
module rstatus_reader #(
    parameter int CNT_W = 8,
    parameter int TGT_W = 27
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             stall,
    input  logic             flush,
    input  logic             ex_status_we,
    input  logic [31:0]      ex_status_value,
    input  logic             ex_is_bex,
    input  logic [TGT_W-1:0] ex_target,
    output logic             bex_taken,
    output logic [31:0]      bex_pc,
    output logic             wb_status_we,
    output logic [31:0]      wb_status_value,
    output logic [31:0]      rstatus,
    output logic [2:0]       cause,
    output logic [CNT_W-1:0] cnt_add,
    output logic [CNT_W-1:0] cnt_addi,
    output logic [CNT_W-1:0] cnt_sub
);

    logic        m_valid_r;
    logic [31:0] m_value_r;
    logic        w_valid_r;
    logic [31:0] w_value_r;
    logic [31:0] rstatus_r;
    logic [2:0]  cause_r;
    logic        commit_s;
    logic [31:0] fwd_value_s;

    function automatic logic [2:0] decode_cause(input logic [31:0] v);
        logic [2:0] c;
        case (v)
            32'd0:   c = 3'd0;
            32'd1:   c = 3'd1;
            32'd2:   c = 3'd2;
            32'd3:   c = 3'd3;
            default: c = 3'd4;
        endcase
        return c;
    endfunction

    assign commit_s = w_valid_r & ~stall;

    // X -> M -> W write pipe; a flush kills both the X write and the entry leaving M
    always_ff @(posedge clock) begin
        if (reset) begin
            m_valid_r <= 1'b0;
            m_value_r <= 32'd0;
            w_valid_r <= 1'b0;
            w_value_r <= 32'd0;
        end else if (flush) begin
            m_valid_r <= 1'b0;
            w_valid_r <= 1'b0;
        end else if (!stall) begin
            m_valid_r <= ex_status_we;
            m_value_r <= ex_status_value;
            w_valid_r <= m_valid_r;
            w_value_r <= m_value_r;
        end else begin
            m_valid_r <= m_valid_r;
            w_valid_r <= w_valid_r;
        end
    end

    // Architectural rstatus and its decoded cause, both updated at commit
    always_ff @(posedge clock) begin
        if (reset) begin
            rstatus_r <= 32'd0;
            cause_r   <= 3'd0;
        end else if (commit_s) begin
            rstatus_r <= w_value_r;
            cause_r   <= decode_cause(w_value_r);
        end else begin
            rstatus_r <= rstatus_r;
            cause_r   <= cause_r;
        end
    end

    // bex source: youngest in-flight write first, architectural value last
    always_comb begin
        fwd_value_s = rstatus_r;
        if (m_valid_r) begin
            fwd_value_s = m_value_r;
        end else if (w_valid_r) begin
            fwd_value_s = w_value_r;
        end else begin
            fwd_value_s = rstatus_r;
        end
    end

    assign bex_taken       = ex_is_bex & (fwd_value_s != 32'd0);
    assign bex_pc          = {{(32-TGT_W){1'b0}}, ex_target};
    assign wb_status_we    = w_valid_r;
    assign wb_status_value = w_value_r;
    assign rstatus         = rstatus_r;
    assign cause           = cause_r;

`ifdef RSTATUS_COUNTERS_EN
    logic [CNT_W-1:0] cnt_add_r;
    logic [CNT_W-1:0] cnt_addi_r;
    logic [CNT_W-1:0] cnt_sub_r;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        logic [CNT_W-1:0] r;
        if (v == {CNT_W{1'b1}}) begin
            r = v;
        end else begin
            r = v + {{(CNT_W-1){1'b0}}, 1'b1};
        end
        return r;
    endfunction

    // Saturating per-cause counters, stepped once per committed overflow code
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_add_r  <= {CNT_W{1'b0}};
            cnt_addi_r <= {CNT_W{1'b0}};
            cnt_sub_r  <= {CNT_W{1'b0}};
        end else if (commit_s) begin
            case (w_value_r)
                32'd1:   cnt_add_r  <= sat_inc(cnt_add_r);
                32'd2:   cnt_addi_r <= sat_inc(cnt_addi_r);
                32'd3:   cnt_sub_r  <= sat_inc(cnt_sub_r);
                default: cnt_add_r  <= cnt_add_r;
            endcase
        end else begin
            cnt_add_r  <= cnt_add_r;
            cnt_addi_r <= cnt_addi_r;
            cnt_sub_r  <= cnt_sub_r;
        end
    end

    assign cnt_add  = cnt_add_r;
    assign cnt_addi = cnt_addi_r;
    assign cnt_sub  = cnt_sub_r;
`else
    assign cnt_add  = {CNT_W{1'b0}};
    assign cnt_addi = {CNT_W{1'b0}};
    assign cnt_sub  = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_rstatus_reader.sv
// Scoreboard bench for rstatus_reader: the driver pushes per-cycle expectations from a
// stage-list reference model, a negedge monitor pops and compares them against the DUT.
module tb_rstatus_reader;

    localparam int CNT_W = 2;
    localparam int TGT_W = 27;
    localparam int CMAX  = (1 << CNT_W) - 1;

    logic             clock = 1'b0;
    logic             reset, stall, flush;
    logic             ex_status_we, ex_is_bex;
    logic [31:0]      ex_status_value;
    logic [TGT_W-1:0] ex_target;
    logic             bex_taken, wb_status_we;
    logic [31:0]      bex_pc, wb_status_value, rstatus;
    logic [2:0]       cause;
    logic [CNT_W-1:0] cnt_add, cnt_addi, cnt_sub;

    rstatus_reader #(.CNT_W(CNT_W), .TGT_W(TGT_W)) dut (
        .clock(clock), .reset(reset), .stall(stall), .flush(flush),
        .ex_status_we(ex_status_we), .ex_status_value(ex_status_value),
        .ex_is_bex(ex_is_bex), .ex_target(ex_target),
        .bex_taken(bex_taken), .bex_pc(bex_pc),
        .wb_status_we(wb_status_we), .wb_status_value(wb_status_value),
        .rstatus(rstatus), .cause(cause),
        .cnt_add(cnt_add), .cnt_addi(cnt_addi), .cnt_sub(cnt_sub)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rs;
        logic [2:0]  cs;
        logic        we;
        logic [31:0] wv;
        logic        bt;
        logic [31:0] pc;
        int          ca, cai, csb;
    } exp_t;

    exp_t exp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    // reference model: in-flight writes by stage (0 = M, 1 = W), plus architectural state
    bit          st_v[2];
    logic [31:0] st_d[2];
    logic [31:0] m_rs;
    int          m_ca, m_cai, m_csb;

    function automatic logic [2:0] exp_cause(input logic [31:0] v);
        if (v == 32'd0) return 3'd0;
        if (v == 32'd1) return 3'd1;
        if (v == 32'd2) return 3'd2;
        if (v == 32'd3) return 3'd3;
        return 3'd4;
    endfunction

    function automatic int bump(input int c);
        return (c < CMAX) ? c + 1 : c;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // monitor: one expectation per cycle, compared away from the active edge
    always @(negedge clock) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("rstatus", rstatus, e.rs);
            check("cause", {29'd0, cause}, {29'd0, e.cs});
            check("wb_status_we", {31'd0, wb_status_we}, {31'd0, e.we});
            if (e.we) check("wb_status_value", wb_status_value, e.wv);
            check("bex_taken", {31'd0, bex_taken}, {31'd0, e.bt});
            check("bex_pc", bex_pc, e.pc);
`ifdef RSTATUS_COUNTERS_EN
            check("cnt_add", 32'(cnt_add), 32'(e.ca));
            check("cnt_addi", 32'(cnt_addi), 32'(e.cai));
            check("cnt_sub", 32'(cnt_sub), 32'(e.csb));
`else
            check("cnt_add", 32'(cnt_add), 32'd0);
            check("cnt_addi", 32'(cnt_addi), 32'd0);
            check("cnt_sub", 32'(cnt_sub), 32'd0);
`endif
        end
    end

    task automatic model_clear();
        st_v[0] = 1'b0; st_v[1] = 1'b0;
        st_d[0] = 32'd0; st_d[1] = 32'd0;
        m_rs = 32'd0; m_ca = 0; m_cai = 0; m_csb = 0;
    endtask

    task automatic model_commit();
        m_rs = st_d[1];
        case (st_d[1])
            32'd1:   m_ca  = bump(m_ca);
            32'd2:   m_cai = bump(m_cai);
            32'd3:   m_csb = bump(m_csb);
            default: ;
        endcase
    endtask

    // one clock cycle: apply inputs, push expectation, advance model at the edge
    task automatic cyc(input bit rst, input bit stl, input bit fl, input bit we,
                       input logic [31:0] val, input bit bex, input logic [TGT_W-1:0] tgt);
        exp_t e;
        logic [31:0] src;
        reset = rst; stall = stl; flush = fl;
        ex_status_we = we; ex_status_value = val; ex_is_bex = bex; ex_target = tgt;
        src   = st_v[0] ? st_d[0] : (st_v[1] ? st_d[1] : m_rs);
        e.rs  = m_rs;
        e.cs  = exp_cause(m_rs);
        e.we  = st_v[1];
        e.wv  = st_d[1];
        e.bt  = bex && (src != 32'd0);
        e.pc  = 32'(tgt);
        e.ca  = m_ca; e.cai = m_cai; e.csb = m_csb;
        exp_q.push_back(e);
        @(posedge clock);
        if (rst) begin
            model_clear();
        end else begin
            if (st_v[1] && !stl) model_commit();
            if (fl) begin
                st_v[0] = 1'b0; st_v[1] = 1'b0;
            end else if (!stl) begin
                st_v[1] = st_v[0]; st_d[1] = st_d[0];
                st_v[0] = we;      st_d[0] = val;
            end
        end
        #1;
    endtask

    task automatic idle(input int n, input bit bex);
        for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, bex, 27'h5a5a5a5);
    endtask

    initial begin
        logic [31:0] v;
        bit rr, ss, ff;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        ex_status_we = 1'b0; ex_status_value = 32'd0; ex_is_bex = 1'b0; ex_target = '0;
        model_clear();
        repeat (2) @(posedge clock);
        #1;
        // reset state, bex with nothing pending
        cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'd7, 1'b0, 27'd0);
        idle(3, 1'b1);
        // overflow code 3 forwarded from M, then committed
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 27'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 27'h7ffffff);
        idle(3, 1'b1);
        // setx then zero: M value 0 wins the forward
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h12345, 1'b0, 27'd1);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 27'd2);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 27'd3);
        idle(3, 1'b1);
        // flushed write never commits
        cyc(1'b0, 1'b0, 1'b1, 1'b1, 32'd2, 1'b0, 27'd0);
        idle(4, 1'b1);
        // stall while the write sits in W
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 27'd0);
        idle(1, 1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 27'd9);
        idle(3, 1'b1);
        // back-to-back commits of code 1 drive cnt_add into saturation
        for (int i = 0; i < 5; i++) cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 27'd0);
        idle(3, 1'b1);
        // reset with writes in flight
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd2, 1'b0, 27'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'd3, 1'b0, 27'd0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1, 32'd1, 1'b0, 27'd0);
        idle(3, 1'b1);
        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            rr = ($urandom_range(0, 99) == 0);
            ss = ($urandom_range(0, 4) == 0);
            ff = !ss && ($urandom_range(0, 7) == 0);
            v  = $urandom_range(0, 4);
            if (v == 32'd4) v = $urandom;
            cyc(rr, ss, ff, 1'($urandom_range(0, 1)), v, 1'($urandom_range(0, 1)),
                27'($urandom));
        end
        idle(1, 1'b0);
        @(negedge clock);
        n_chk++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
